tile_writeback_engine: RTL

//  Streams a GRID_R x GRID_C grid of TILE_R x TILE_C result tiles into a multi-port RAM as one
//  row-major matrix. Sits after the tiled matrix-multiply array and ahead of the result RAM.

---
 rtl/tile_writeback_engine.sv | 131 +++++++++++++
 1 files changed

// File: rtl/tile_writeback_engine.sv
// tile_writeback_engine: streams a GRID_R x GRID_C grid of TILE_R x TILE_C tiles into a
// multi-port RAM as one row-major matrix, NPORTS consecutive columns per beat.
//   clk, rst          clock (rising edge), synchronous active-high reset
//   i_start           request a pass; sampled only while idle (including the done cycle)
//   i_base_addr       matrix origin in RAM, captured when start is accepted
//   i_tiles_in        all tiles flattened, element idx at [idx*WIDTH +: WIDTH]; stable while busy
//   i_ram_ready       RAM accepts a beat at this edge
//   o_wr_en           per-port write enable (all ports fire together)
//   o_wr_addr         port p address at [p*ADDR_WIDTH +: ADDR_WIDTH]
//   o_wr_data         port p data at [p*WIDTH +: WIDTH]
//   o_busy, o_done    pass in progress / one-cycle pulse after the last beat
module tile_writeback_engine #(
   parameter int TILE_R     = 4,
   parameter int TILE_C     = 4,
   parameter int WIDTH      = 32,
   parameter int GRID_R     = 4,
   parameter int GRID_C     = 4,
   parameter int NPORTS     = 4,
   parameter int ADDR_WIDTH = 10
) (
   input  logic                                         clk,
   input  logic                                         rst,
   input  logic                                         i_start,
   input  logic [ADDR_WIDTH-1:0]                        i_base_addr,
   input  logic [GRID_R*GRID_C*TILE_R*TILE_C*WIDTH-1:0] i_tiles_in,
   input  logic                                         i_ram_ready,
   output logic [NPORTS-1:0]                            o_wr_en,
   output logic [NPORTS*ADDR_WIDTH-1:0]                 o_wr_addr,
   output logic [NPORTS*WIDTH-1:0]                      o_wr_data,
   output logic                                         o_busy,
   output logic                                         o_done
);
   localparam int SEGS       = TILE_C / NPORTS;
   localparam int TOTAL_BITS = GRID_R * GRID_C * TILE_R * TILE_C * WIDTH;
   localparam int BW         = $clog2(TOTAL_BITS);
   localparam int GRW        = GRID_R > 1 ? $clog2(GRID_R) : 1;
   localparam int RW         = TILE_R > 1 ? $clog2(TILE_R) : 1;
   localparam int GCW        = GRID_C > 1 ? $clog2(GRID_C) : 1;
   localparam int SW         = SEGS > 1 ? $clog2(SEGS) : 1;

   generate
      if (TILE_C % NPORTS != 0) begin : g_bad_cfg
         $error("TILE_C must be a multiple of NPORTS");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;
   state_t r_state;

   // Walk order: matrix row (gr, r) outermost, then tile column gc, then segment s.
   // This makes the RAM address a plain running counter from the base.
   logic [GRW-1:0]              r_gr;
   logic [RW-1:0]               r_r;
   logic [GCW-1:0]              r_gc;
   logic [SW-1:0]               r_s;
   logic [ADDR_WIDTH-1:0]       r_addr;
   logic                        w_s_last, w_gc_last, w_r_last, w_gr_last, w_last;
   logic [31:0]                 w_elem0;
   logic [NPORTS*ADDR_WIDTH-1:0] w_addr;
   logic [NPORTS*WIDTH-1:0]     w_data;

   assign w_s_last  = r_s == SW'(SEGS - 1);
   assign w_gc_last = r_gc == GCW'(GRID_C - 1);
   assign w_r_last  = r_r == RW'(TILE_R - 1);
   assign w_gr_last = r_gr == GRW'(GRID_R - 1);
   assign w_last    = w_s_last && w_gc_last && w_r_last && w_gr_last;

   // Flat tile index of the element feeding port 0 of the current beat.
   assign w_elem0 = ((32'(r_gr) * GRID_C + 32'(r_gc)) * TILE_R + 32'(r_r)) * TILE_C
                    + 32'(r_s) * NPORTS;

   generate
      for (genvar p = 0; p < NPORTS; p++) begin : g_port
         logic [BW-1:0] w_bit;
         assign w_bit = BW'((w_elem0 + 32'(p)) * 32'(WIDTH));
         assign w_data[p*WIDTH +: WIDTH] = i_tiles_in[w_bit +: WIDTH];
         assign w_addr[p*ADDR_WIDTH +: ADDR_WIDTH] = r_addr + ADDR_WIDTH'(p);
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         o_wr_en   <= '0;
         o_wr_addr <= '0;
         o_wr_data <= '0;
         o_busy    <= 1'b0;
         o_done    <= 1'b0;
         r_addr    <= '0;
         r_gr      <= '0;
         r_r       <= '0;
         r_gc      <= '0;
         r_s       <= '0;
      end else begin
         o_wr_en <= '0;
         o_done  <= 1'b0;
         case (r_state)
            IDLE: if (i_start) begin
               r_state <= WRITE;
               o_busy  <= 1'b1;
               r_addr  <= i_base_addr;
               r_gr    <= '0;
               r_r     <= '0;
               r_gc    <= '0;
               r_s     <= '0;
            end
            WRITE: if (i_ram_ready) begin
               o_wr_en   <= '1;
               o_wr_addr <= w_addr;
               o_wr_data <= w_data;
               r_addr    <= r_addr + ADDR_WIDTH'(NPORTS);
               r_s       <= w_s_last ? '0 : r_s + 1'b1;
               if (w_s_last)
                  r_gc <= w_gc_last ? '0 : r_gc + 1'b1;
               if (w_s_last && w_gc_last)
                  r_r <= w_r_last ? '0 : r_r + 1'b1;
               if (w_s_last && w_gc_last && w_r_last)
                  r_gr <= w_gr_last ? '0 : r_gr + 1'b1;
               if (w_last)
                  r_state <= DONE;
            end
            DONE: begin
               o_done  <= 1'b1;
               o_busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule
